// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, data width and baud divisor helper.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, head visible on o_rdata while non-empty.
// Ports: clk, rst (async, active-high), i_push/i_wdata (ignored when full),
// i_pop (ignored when empty), o_rdata, o_full, o_empty, o_count.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_full = r_count == (AW + 1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      r_wptr <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_wdata;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN).
// Ports: clk_50M, ext_reset (async, active-high), wdata/wvalid/wready push
// handshake, txd serial line (idle high), busy, fifo_count.
// Macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
import uart_pkg::*;
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_50M,
  input  logic                          ext_reset,
  input  logic [7:0]                    wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t AFTER_DATA = PARITY;
  logic r_par;
`else
  localparam uart_tx_state_t AFTER_DATA = STOP;
`endif
  uart_tx_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt, w_head;
  logic r_txd, w_txd_nxt, w_pop, w_full, w_empty, w_tick;
  sync_fifo #(.W(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_50M),
    .rst(ext_reset),
    .i_push(wvalid),
    .i_pop(w_pop),
    .i_wdata(wdata),
    .o_rdata(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(fifo_count)
  );
  assign w_tick = r_cnt == '0;
  always_ff @(posedge clk_50M or posedge ext_reset) begin
    if (ext_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_bit <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      if (w_pop) r_par <= ^w_head;
`endif
    end
  end
  // STOP pops on its final cycle so the next start bit follows with no gap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = w_tick ? RELOAD : r_cnt - CW'(1);
    w_bit_nxt = r_bit;
    w_shift_nxt = r_shift;
    w_pop = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop = 1'b1;
          w_state_nxt = START;
          w_cnt_nxt = RELOAD;
          w_shift_nxt = w_head;
        end
      end
      START: if (w_tick) begin
        w_state_nxt = DATA;
        w_bit_nxt = '0;
      end
      DATA: if (w_tick) begin
        w_shift_nxt = r_shift >> 1;
        w_bit_nxt = r_bit + 3'd1;
        w_state_nxt = (r_bit == 3'(UART_DATA_BITS - 1)) ? AFTER_DATA : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_state_nxt = STOP;
`endif
      STOP: if (w_tick) begin
        w_pop = !w_empty;
        w_state_nxt = w_empty ? IDLE : START;
        w_shift_nxt = w_empty ? r_shift : w_head;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // txd is registered from the level the next state will drive.
  always_comb begin
    w_txd_nxt = 1'b1;
    if (w_state_nxt == START) w_txd_nxt = 1'b0;
    else if (w_state_nxt == DATA) w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
    else if (w_state_nxt == PARITY) w_txd_nxt = r_par;
`endif
  end
  always_comb begin
    txd = r_txd;
    wready = !w_full;
    busy = !w_empty || r_state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo at DIV=10 plus a 115200-baud rounding instance.
module tb_uart_tx_fifo;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk_50M = 1'b0;
  logic ext_reset = 1'b1;
  logic [7:0] wdata = '0;
  logic wvalid = 1'b0;
  logic wready, txd, busy;
  logic [4:0] fifo_count;
  logic [7:0] r2_wdata = '0;
  logic r2_wvalid = 1'b0;
  logic r2_wready, r2_txd, r2_busy;
  logic [4:0] r2_count;
  int checks = 0;
  int failures = 0;
  int frames = 0;
  int idle_run = 0;
  int gap_last = 0;
  logic last_par = 1'b0;
  logic [7:0] sbq[$];

  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(5000000), .FIFO_DEPTH(16)) dut (
    .clk_50M(clk_50M), .ext_reset(ext_reset), .wdata(wdata), .wvalid(wvalid),
    .wready(wready), .txd(txd), .busy(busy), .fifo_count(fifo_count)
  );
  uart_tx_fifo #(.CLK_FREQ(50000000), .BAUD(115200), .FIFO_DEPTH(16)) dut_r (
    .clk_50M(clk_50M), .ext_reset(ext_reset), .wdata(r2_wdata), .wvalid(r2_wvalid),
    .wready(r2_wready), .txd(r2_txd), .busy(r2_busy), .fifo_count(r2_count)
  );

  always #10 clk_50M = ~clk_50M;

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Receiver: samples every cycle of a frame, checks every sample against the
  // ideal waveform for the decoded byte, and scores the byte against the queue.
  initial begin : mon
    logic [NB*DIV-1:0] smp;
    logic [7:0] b, e;
    logic lvl, ok, ab;
    int j;
    forever begin
      @(negedge clk_50M);
      if (ext_reset || txd !== 1'b0) idle_run++;
      else begin
        gap_last = idle_run;
        idle_run = 0;
        ab = 1'b0;
        smp[0] = txd;
        for (int k = 1; k < NB * DIV; k++) begin
          @(negedge clk_50M);
          smp[k] = txd;
          if (ext_reset) ab = 1'b1;
        end
        if (!ab) begin
          for (int i = 0; i < 8; i++) b[i] = smp[DIV * (i + 1) + DIV / 2];
          ok = 1'b1;
          for (int k = 0; k < NB * DIV; k++) begin
            j = k / DIV;
            lvl = (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : (j == NB - 1) ? 1'b1 : ^b;
            if (smp[k] !== lvl) ok = 1'b0;
          end
          last_par = smp[9 * DIV + DIV / 2];
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL frame_shape byte=%02h samples=%b", b, smp);
          end
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%02h expected=none", b);
          end else begin
            e = sbq.pop_front();
            if (b !== e) begin
              failures++;
              $display("FAIL frame_byte got=%02h expected=%02h", b, e);
            end
          end
          frames++;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    @(posedge clk_50M);
    #1 wdata = d;
    wvalid = 1'b1;
    sbq.push_back(d);
    @(posedge clk_50M);
    #1 wvalid = 1'b0;
  endtask

  task automatic test_reset;
    ext_reset = 1'b1;
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b expected=1", txd); end
    checks++;
    if (wready !== 1'b1) begin failures++; $display("FAIL reset_wready got=%b expected=1", wready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    checks++;
    if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d expected=0", fifo_count); end
    @(posedge clk_50M);
    #1 ext_reset = 1'b0;
    repeat (3) @(posedge clk_50M);
  endtask

  task automatic test_single;
    int f0;
    f0 = frames;
    push_byte(8'h55);
    @(negedge clk_50M);
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL single_txd_before_pop got=%b expected=1", txd); end
    checks++;
    if (fifo_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d expected=1", fifo_count); end
    @(negedge clk_50M);
    checks++;
    if (txd !== 1'b0) begin failures++; $display("FAIL single_start_latency got=%b expected=0", txd); end
    repeat (99) @(negedge clk_50M);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_stop got=%b expected=1", busy); end
    @(negedge clk_50M);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b expected=0", busy); end
    for (int i = 0; i < 50 && frames < f0 + 1; i++) @(negedge clk_50M);
    checks++;
    if (frames !== f0 + 1) begin failures++; $display("FAIL single_frames got=%0d expected=%0d", frames, f0 + 1); end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = frames;
    @(posedge clk_50M);
    #1 wdata = 8'hA3;
    wvalid = 1'b1;
    sbq.push_back(8'hA3);
    @(posedge clk_50M);
    #1 wdata = 8'h0F;
    sbq.push_back(8'h0F);
    @(posedge clk_50M);
    #1 wvalid = 1'b0;
    for (int i = 0; i < 3 * NB * DIV && frames < f0 + 2; i++) @(negedge clk_50M);
    checks++;
    if (frames !== f0 + 2) begin failures++; $display("FAIL b2b_frames got=%0d expected=%0d", frames, f0 + 2); end
    checks++;
    if (gap_last !== 0) begin failures++; $display("FAIL b2b_gap got=%0d expected=0", gap_last); end
    repeat (2) @(negedge clk_50M);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b expected=0", busy); end
  endtask

  task automatic test_full;
    int f0, acc, peak;
    f0 = frames;
    acc = 0;
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_50M);
      #1 wdata = 8'h40 + 8'(i);
      wvalid = 1'b1;
      @(negedge clk_50M);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (wready) begin
        sbq.push_back(wdata);
        acc++;
      end
    end
    @(posedge clk_50M);
    #1 wvalid = 1'b0;
    @(negedge clk_50M);
    checks++;
    if (acc !== 17) begin failures++; $display("FAIL full_accepted got=%0d expected=17", acc); end
    checks++;
    if (peak !== 16) begin failures++; $display("FAIL full_peak got=%0d expected=16", peak); end
    checks++;
    if (wready !== 1'b0 || fifo_count !== 5'd16) begin
      failures++;
      $display("FAIL full_hold got wready=%b count=%0d expected wready=0 count=16", wready, fifo_count);
    end
    for (int i = 0; i < 19 * NB * DIV && frames < f0 + 17; i++) @(negedge clk_50M);
    checks++;
    if (frames !== f0 + 17) begin failures++; $display("FAIL full_frames got=%0d expected=%0d", frames, f0 + 17); end
    checks++;
    if (sbq.size() !== 0) begin failures++; $display("FAIL full_leftover got=%0d expected=0", sbq.size()); end
    repeat (3) @(negedge clk_50M);
  endtask

  task automatic test_reset_mid;
    int f0, low;
    @(posedge clk_50M);
    #1 wvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 8'hC0 + 8'(i);
      sbq.push_back(wdata);
      @(posedge clk_50M);
      #1;
    end
    wvalid = 1'b0;
    repeat (40) @(negedge clk_50M);
    checks++;
    if (fifo_count !== 5'd5 || txd !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pre got count=%0d txd=%b expected count=5 txd=0", fifo_count, txd);
    end
    #3 ext_reset = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin failures++; $display("FAIL midreset_txd got=%b expected=1", txd); end
    checks++;
    if (fifo_count !== 5'd0) begin failures++; $display("FAIL midreset_count got=%0d expected=0", fifo_count); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b expected=0", busy); end
    checks++;
    if (wready !== 1'b1) begin failures++; $display("FAIL midreset_wready got=%b expected=1", wready); end
    sbq.delete();
    repeat (3) @(posedge clk_50M);
    #1 ext_reset = 1'b0;
    f0 = frames;
    low = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_50M);
      if (txd !== 1'b1) low++;
    end
    checks++;
    if (low !== 0) begin failures++; $display("FAIL midreset_quiet low_cycles=%0d expected=0", low); end
    checks++;
    if (frames !== f0) begin failures++; $display("FAIL midreset_frames got=%0d expected=%0d", frames, f0); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int f0;
    f0 = frames;
    push_byte(8'h07);
    for (int i = 0; i < 2 * NB * DIV && frames < f0 + 1; i++) @(negedge clk_50M);
    checks++;
    if (frames !== f0 + 1 || last_par !== 1'b1) begin
      failures++;
      $display("FAIL parity_07 got frames=%0d par=%b expected frames=%0d par=1", frames, last_par, f0 + 1);
    end
    push_byte(8'h55);
    for (int i = 0; i < 2 * NB * DIV && frames < f0 + 2; i++) @(negedge clk_50M);
    checks++;
    if (frames !== f0 + 2 || last_par !== 1'b0) begin
      failures++;
      $display("FAIL parity_55 got frames=%0d par=%b expected frames=%0d par=0", frames, last_par, f0 + 2);
    end
    repeat (3) @(negedge clk_50M);
  endtask
`endif

  task automatic test_rounding;
    int w;
    @(posedge clk_50M);
    #1 r2_wdata = 8'h01;
    r2_wvalid = 1'b1;
    @(posedge clk_50M);
    #1 r2_wvalid = 1'b0;
    for (int i = 0; i < 10 && r2_txd !== 1'b0; i++) @(negedge clk_50M);
    w = 0;
    for (int i = 0; i < 2000 && r2_txd === 1'b0; i++) begin
      w++;
      @(negedge clk_50M);
    end
    checks++;
    if (w !== 434) begin failures++; $display("FAIL rounding_start_width got=%0d expected=434", w); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_rounding();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
